// File: rtl/sram_tree_loader.sv
// Streams words into consecutive SRAM addresses from a programmed base and can
// read the region back to confirm its additive checksum.
module sram_tree_loader #(
   parameter int DATA_BUS_WIDTH = 64,
   parameter int ADDR_BUS_WIDTH = 64,
   parameter int LEN_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_start,
   input  logic [ADDR_BUS_WIDTH-1:0] load_base_addr,
   input  logic [LEN_WIDTH-1:0]      load_len,
   input  logic                      verify_en,
   input  logic [DATA_BUS_WIDTH-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      mem_sram_CEN,
   output logic [ADDR_BUS_WIDTH-1:0] mem_sram_A,
   output logic [DATA_BUS_WIDTH-1:0] mem_sram_D,
   output logic                      mem_sram_GWEN,
   input  logic [DATA_BUS_WIDTH-1:0] mem_sram_Q,
   output logic                      load_busy,
   output logic                      load_done,
   output logic                      load_err,
   output logic [DATA_BUS_WIDTH-1:0] load_checksum
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WFLUSH, S_VERIFY, S_VCMP, S_DONE
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [ADDR_BUS_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]      r_len;
   logic                      r_verify;
   logic [LEN_WIDTH-1:0]      r_wr_cnt;
   logic [LEN_WIDTH-1:0]      r_rd_cnt;
   logic                      r_cen, r_gwen;
   logic [ADDR_BUS_WIDTH-1:0] r_a;
   logic [DATA_BUS_WIDTH-1:0] r_d;
   logic                      r_q_vld;
   logic [DATA_BUS_WIDTH-1:0] r_rd_sum;
   logic [DATA_BUS_WIDTH-1:0] r_checksum;
   logic                      r_err;

   logic                      w_hs;
   logic                      w_last_wr;
   logic [DATA_BUS_WIDTH-1:0] w_rd_sum_nxt;

   function automatic logic [ADDR_BUS_WIDTH-1:0] f_addr(
      input logic [ADDR_BUS_WIDTH-1:0] base,
      input logic [LEN_WIDTH-1:0]      idx
   );
      return base + ADDR_BUS_WIDTH'(idx);
   endfunction

   function automatic logic [DATA_BUS_WIDTH-1:0] f_sum(
      input logic [DATA_BUS_WIDTH-1:0] a,
      input logic [DATA_BUS_WIDTH-1:0] b
   );
      return a + b;
   endfunction

   assign in_ready      = (r_state == S_WRITE) && (r_wr_cnt < r_len);
   assign w_hs          = in_valid && in_ready;
   assign w_last_wr     = w_hs && ((r_wr_cnt + LEN_WIDTH'(1)) == r_len);
   // Q returns one cycle after each read cycle, so r_q_vld marks the cycle it is valid.
   assign w_rd_sum_nxt  = r_q_vld ? f_sum(r_rd_sum, mem_sram_Q) : r_rd_sum;

   assign mem_sram_CEN  = r_cen;
   assign mem_sram_GWEN = r_gwen;
   assign mem_sram_A    = r_a;
   assign mem_sram_D    = r_d;
   assign load_err      = r_err;
   assign load_checksum = r_checksum;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      load_busy   = (r_state != S_IDLE);
      load_done   = (r_state == S_DONE);
      case (r_state)
         S_IDLE:   if (load_start) w_state_nxt = (load_len == '0) ? S_DONE : S_WRITE;
         S_WRITE:  if (w_last_wr) w_state_nxt = S_WFLUSH;
         S_WFLUSH: w_state_nxt = r_verify ? S_VERIFY : S_DONE;
         S_VERIFY: if (r_rd_cnt == r_len) w_state_nxt = S_VCMP;
         S_VCMP:   w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base     <= '0;
         r_len      <= '0;
         r_verify   <= 1'b0;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_cen      <= 1'b1;
         r_gwen     <= 1'b1;
         r_a        <= '0;
         r_d        <= '0;
         r_q_vld    <= 1'b0;
         r_rd_sum   <= '0;
         r_checksum <= '0;
         r_err      <= 1'b0;
      end else begin
         r_cen    <= 1'b1;
         r_gwen   <= 1'b1;
         r_q_vld  <= !r_cen && r_gwen;
         r_rd_sum <= w_rd_sum_nxt;
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  r_base     <= load_base_addr;
                  r_len      <= load_len;
                  r_verify   <= verify_en;
                  r_wr_cnt   <= '0;
                  r_rd_cnt   <= '0;
                  r_rd_sum   <= '0;
                  r_checksum <= '0;
                  r_err      <= 1'b0;
               end
            end
            S_WRITE: begin
               if (w_hs) begin
                  r_cen      <= 1'b0;
                  r_gwen     <= 1'b0;
                  r_a        <= f_addr(r_base, r_wr_cnt);
                  r_d        <= in_data;
                  r_wr_cnt   <= r_wr_cnt + LEN_WIDTH'(1);
                  r_checksum <= f_sum(r_checksum, in_data);
               end
            end
            // First read is launched here so reads run back to back through VERIFY.
            S_WFLUSH: begin
               if (r_verify) begin
                  r_cen    <= 1'b0;
                  r_a      <= r_base;
                  r_rd_cnt <= LEN_WIDTH'(1);
               end
            end
            S_VERIFY: begin
               if (r_rd_cnt != r_len) begin
                  r_cen    <= 1'b0;
                  r_a      <= f_addr(r_base, r_rd_cnt);
                  r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
               end
            end
            S_VCMP:  r_err <= (w_rd_sum_nxt != r_checksum);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_tree_loader.sv
// Randomized bench for sram_tree_loader against a behavioural SRAM and a
// transaction-level expectation of writes, reads, checksum and completion time.
module tb_sram_tree_loader;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [AW-1:0] load_base_addr;
   logic [LW-1:0] load_len;
   logic          verify_en;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_sram_CEN;
   logic [AW-1:0] mem_sram_A;
   logic [DW-1:0] mem_sram_D;
   logic          mem_sram_GWEN;
   logic [DW-1:0] mem_sram_Q = '0;
   logic          load_busy;
   logic          load_done;
   logic          load_err;
   logic [DW-1:0] load_checksum;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   sram_tree_loader #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_base_addr(load_base_addr),
      .load_len(load_len), .verify_en(verify_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_sram_CEN(mem_sram_CEN), .mem_sram_A(mem_sram_A),
      .mem_sram_D(mem_sram_D), .mem_sram_GWEN(mem_sram_GWEN), .mem_sram_Q(mem_sram_Q),
      .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
      .load_checksum(load_checksum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural synchronous SRAM: write on GWEN low, registered read data otherwise.
   logic [DW-1:0] mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (!mem_sram_CEN) begin
         if (!mem_sram_GWEN) mem[mem_sram_A] = mem_sram_D;
         else mem_sram_Q <= mem.exists(mem_sram_A) ? mem[mem_sram_A] : '0;
      end
   end

   typedef struct {
      int            c;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } acc_t;
   acc_t wq[$];
   acc_t rq[$];

   always @(negedge clk) begin
      if (!rst && !mem_sram_CEN) begin
         if (!mem_sram_GWEN) wq.push_back('{cyc, mem_sram_A, mem_sram_D});
         else                rq.push_back('{cyc, mem_sram_A, '0});
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete load. mode: 0 valid held, 1 valid alternating, 2 random valid.
   task automatic run_load(input logic [AW-1:0] base, input int n, input bit ver,
                           input int mode, input int corr, input bit poke, input bit seq);
      logic [DW-1:0] w[$];
      logic [DW-1:0] sum;
      logic [AW-1:0] ea;
      int            hsq[$];
      int            idx, s, c, L, dcyc, to, exp_done;
      bit            v, done_seen, corrupted, err_exp;
      w.delete(); hsq.delete();
      sum = '0;
      for (int i = 0; i < n; i++) begin
         w.push_back(seq ? DW'(i + 1) : {$urandom, $urandom});
         sum += w[i];
      end
      wq.delete(); rq.delete();
      @(negedge clk);
      load_base_addr = base; load_len = LW'(n); verify_en = ver;
      load_start = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      load_start = 1'b0;
      s = cyc; idx = 0; L = 0; dcyc = 0; to = 0;
      done_seen = 1'b0; corrupted = 1'b0;
      while (!done_seen && to < 2000) begin
         c = cyc - s + 1;
         if (c == 1) begin
            check_val("err_clear_on_start", load_err, 0);
            check_val("sum_clear_on_start", load_checksum, 0);
         end
         if (load_done) begin
            done_seen = 1'b1; dcyc = c;
         end else begin
            check_val("in_ready", in_ready, (idx < n));
            if (idx < n) v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
            else v = 1'b0;
            in_valid = v;
            in_data  = v ? w[idx] : {$urandom, $urandom};
            if (v && in_ready) begin
               hsq.push_back(c);
               idx++;
               if (idx == n) L = c;
            end
            if (poke && c == 3) begin
               load_start = 1'b1; load_base_addr = ~base; load_len = LW'(7);
            end else load_start = 1'b0;
            if (corr >= 0 && !corrupted && !mem_sram_CEN && mem_sram_GWEN) begin
               ea = base + AW'(corr);
               mem[ea] = '0;
               corrupted = 1'b1;
            end
            @(negedge clk);
            to++;
         end
      end
      in_valid = 1'b0; load_start = 1'b0;
      check_val("done_seen", done_seen, 1);
      exp_done = (n == 0) ? 1 : L + 2 + (ver ? n + 1 : 0);
      check_val("done_cycle", dcyc, exp_done);
      check_val("checksum", load_checksum, sum);
      err_exp = ver && corr >= 0 && corr < n && w[corr] != '0;
      check_val("load_err", load_err, err_exp);
      check_val("write_count", wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) begin
         ea = base + AW'(i);
         check_val("wr_addr", wq[i].a, ea);
         check_val("wr_data", wq[i].d, w[i]);
         check_val("wr_cycle", wq[i].c - s + 1, hsq[i] + 1);
      end
      check_val("read_count", rq.size(), ver ? n : 0);
      for (int i = 0; i < rq.size() && i < n; i++) begin
         ea = base + AW'(i);
         check_val("rd_addr", rq[i].a, ea);
         check_val("rd_cycle", rq[i].c - s + 1, L + 2 + i);
      end
      @(negedge clk);
      check_val("done_one_cycle", load_done, 0);
      check_val("busy_idle", load_busy, 0);
      check_val("ready_idle", in_ready, 0);
      check_val("sum_hold", load_checksum, sum);
      check_val("err_hold", load_err, err_exp);
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; load_base_addr = '0; load_len = '0;
      verify_en = 1'b0; in_data = '0; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_cen", mem_sram_CEN, 1);
      check_val("rst_gwen", mem_sram_GWEN, 1);
      check_val("rst_a", mem_sram_A, 0);
      check_val("rst_d", mem_sram_D, 0);
      check_val("rst_ready", in_ready, 0);
      check_val("rst_busy", load_busy, 0);
      check_val("rst_done", load_done, 0);
      check_val("rst_err", load_err, 0);
      check_val("rst_sum", load_checksum, 0);
      rst = 1'b0;

      run_load(64'h10, 4, 1'b0, 0, -1, 1'b0, 1'b1);
      check_val("len4_sum_10", load_checksum, 64'd10);
      run_load(64'h10, 4, 1'b1, 0, -1, 1'b0, 1'b1);
      run_load(64'h10, 4, 1'b1, 0, 2, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_val("err_held_idle", load_err, 1);
      run_load(64'h40, 3, 1'b0, 1, -1, 1'b1, 1'b0);
      run_load(64'h99, 0, 1'b1, 0, -1, 1'b0, 1'b0);
      run_load({AW{1'b1}}, 2, 1'b1, 0, -1, 1'b0, 1'b0);

      // Abort after two accepted beats of a four-word load.
      @(negedge clk);
      load_base_addr = 64'h10; load_len = LW'(4); verify_en = 1'b0; load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0; in_valid = 1'b1; in_data = 64'hA;
      @(negedge clk);
      in_data = 64'hB;
      @(negedge clk);
      rst = 1'b1; in_data = 64'hC;
      @(negedge clk);
      check_val("abort_cen", mem_sram_CEN, 1);
      check_val("abort_ready", in_ready, 0);
      check_val("abort_busy", load_busy, 0);
      check_val("abort_sum", load_checksum, 0);
      check_val("abort_done", load_done, 0);
      rst = 1'b0; in_valid = 1'b0;
      run_load(64'h10, 4, 1'b0, 0, -1, 1'b0, 1'b1);

      for (int k = 0; k < 4; k++)
         run_load({$urandom, $urandom}, $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                  2, -1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_tree_loader.md
Name: sram_tree_loader

Overview:
- Writer side of the octree SRAM port: accepts a valid/ready stream of DATA_BUS_WIDTH-bit words and writes them into consecutive SRAM addresses, starting at a programmed base.
- Drives the same CEN/GWEN/A/D/Q synchronous-SRAM interface that tree_search reads from, and preloads tree nodes and features before a search starts.
- Optional read-back verify pass: recomputes an additive checksum over the written region and flags any mismatch.

Parameters:
- DATA_BUS_WIDTH, 64, SRAM data word width.
- ADDR_BUS_WIDTH, 64, SRAM address width.
- LEN_WIDTH, 10, width of the word-count field.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  start pulse; sampled only in IDLE.
- load_base_addr  input  ADDR_BUS_WIDTH  first SRAM address; latched on accepted start.
- load_len  input  LEN_WIDTH  number of words N; latched on accepted start.
- verify_en  input  1  enables the read-back pass; latched on accepted start.
- in_data  input  DATA_BUS_WIDTH  stream word.
- in_valid  input  1  stream valid.
- in_ready  output  1  stream ready.
- mem_sram_CEN  output  1  chip enable, active low.
- mem_sram_A  output  ADDR_BUS_WIDTH  address.
- mem_sram_D  output  DATA_BUS_WIDTH  write data.
- mem_sram_GWEN  output  1  write enable, active low.
- mem_sram_Q  input  DATA_BUS_WIDTH  read data, valid one cycle after a read cycle.
- load_busy  output  1  high in every state except IDLE.
- load_done  output  1  one-cycle completion pulse.
- load_err  output  1  verify checksum mismatch.
- load_checksum  output  DATA_BUS_WIDTH  sum of written words, modulo 2^DATA_BUS_WIDTH.

Behaviour:
- Reset values (one cycle after rst is high): state IDLE; CEN=1, GWEN=1, A=0, D=0; in_ready=0, load_busy=0, load_done=0, load_err=0, load_checksum=0; all counters 0.
- Reset mid-operation: abort to IDLE and deassert CEN/GWEN next cycle. In-flight beats are dropped.
- SRAM outputs (CEN, GWEN, A, D) are registered. in_ready = (state==WRITE) && (wr_cnt<N), combinational.
- States: IDLE, WRITE, WFLUSH, VERIFY, VCMP, DONE.
- IDLE:
  - On load_start: latch base, N and verify_en; clear wr_cnt, load_checksum and load_err.
  - N==0 goes directly to DONE. Otherwise go to WRITE.
  - load_start in any other state is ignored.
- WRITE:
  - Each handshake (in_valid&&in_ready) at edge k drives CEN=0, GWEN=0, A=base+wr_cnt, D=in_data during cycle k+1.
  - Each handshake increments wr_cnt and adds in_data to load_checksum.
  - Cycles without a handshake present CEN=1.
  - The edge carrying the N-th handshake moves the state to WFLUSH; in_ready is 0 from then on.
- WFLUSH: one cycle; the last write is on the bus. Next state is VERIFY if verify_en, else DONE.
- VERIFY:
  - Presents N read cycles back to back: CEN=0, GWEN=1, A=base+i for i=0..N-1.
  - Q is sampled at the edge ending the cycle after each read and summed into rd_sum.
  - After the last read cycle, go to VCMP.
- VCMP:
  - One cycle with CEN=1; the final Q is sampled at its end.
  - Next state DONE, with load_err = (rd_sum+final Q != load_checksum).
- DONE: load_done=1 for exactly one cycle, then IDLE. load_err and load_checksum hold until the next accepted start.
- Latency: with in_valid held high and verify off, load_done is asserted in cycle N+2 after the start edge. With verify on, add N+1 cycles.
- Address arithmetic: base+index wraps modulo 2^ADDR_BUS_WIDTH.
- Checksum arithmetic: modulo 2^DATA_BUS_WIDTH, carry discarded.
- Backpressure: in_valid may drop at any time. The FSM waits in WRITE indefinitely with CEN=1.

Test Plan:
- Length 4, no verify: base=0x10, N=4, verify_en=0, words 1,2,3,4 with in_valid held → writes to 0x10..0x13 on consecutive cycles; load_done in cycle 6 after start; load_checksum=10; load_err=0.
- Verify pass: same load with verify_en=1 against the behavioural sram model → 4 reads at 0x10..0x13 after WFLUSH; load_done 5 cycles later than without verify; load_err=0.
- Corrupted read-back: bench forces memory[0x12]=0 before VERIFY → load_err=1 at load_done, held until the next accepted start.
- Gapped stream: in_valid toggles 1,0,1,0 for N=3 → no write cycle during gaps; in_ready=0 after the 3rd beat; load_start pulsed mid-load is ignored.
- Zero length and wrap-around: N=0 → load_done in the next cycle, no CEN=0 cycle. Then base=2^ADDR_BUS_WIDTH-1, N=2 → writes to all-ones address, then address 0.
- Reset mid-operation: rst high after 2 of 4 beats → next cycle CEN=1, in_ready=0, load_busy=0, load_checksum=0; a fresh load then behaves as in the length-4 case.
